adder_seq: RTL and testbench
============================

# adder_seq

Parametrised multi-cycle adder/subtractor for the ALU datapath of the 8-bit CPU. It accepts two WIDTH-bit operands on a start pulse and ripples CHUNK bits per clock through a combinational slice adder. It returns sum, carry-out, signed overflow and zero flags with a one-cycle done pulse. CHUNK trades area against latency: CHUNK=1 is bit-serial, CHUNK=WIDTH is single-cycle.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- CHUNK, 1: bits processed per RUN cycle; WIDTH % CHUNK == 0 is required (elaboration error otherwise).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0: a + b + carry_in; 1: a + ~b + carry_in (caller drives carry_in=1 for plain a − b).
- carry_in  in  1  carry into bit 0.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; latched on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- sum  out  WIDTH  result, registered.
- carry_out  out  1  carry out of bit WIDTH−1.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- NCHUNK = WIDTH / CHUNK. States: IDLE, RUN, DONE.
- **IDLE:** start=1 means accept. Latch a, (sub ? ~b : b) and carry_in into internal registers. Clear chunk index k. Go to RUN. start=0 means stay.
- **RUN:** each cycle, add chunk k of the latched operands plus the running carry and write the chunk into the internal partial-sum register. Update the running carry, then k ← k+1. On the edge where k == NCHUNK−1, copy the partial sum to sum, write carry_out, overflow and zero, and go to DONE. start is ignored in RUN; no queueing.
- **DONE:** done=1 for this cycle only. start=1 is accepted exactly as in IDLE and goes to RUN (back-to-back). Otherwise go to IDLE.
- Outputs sum, carry_out, overflow and zero change only on entry to DONE. They hold their last result through IDLE and through a following RUN.
- Overflow uses the carry into bit WIDTH−1, taken from the final chunk's slice.
- Inputs a, b, sub and carry_in may change freely after accept.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, zero=1. Internal k, carry and partial sum are 0.
- rst asserted mid-RUN aborts the operation on that edge. No done pulse follows, and outputs take their reset values.
- Latency: with start sampled at edge E, done is high in the cycle after edge E+NCHUNK.
  - WIDTH=8, CHUNK=1: 8 cycles.
  - CHUNK=4: 2 cycles.
  - CHUNK=8: 1 cycle.
- busy is high for exactly NCHUNK cycles per operation.
- Throughput with start held high: one result every NCHUNK+1 cycles.
- rst has priority over start on the same edge.

## Structure
- Shared package alu_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the NCHUNK derivation;
  - the index width, clog2(NCHUNK) with a minimum of 1.
- One sub-module, add_slice #(CHUNK): combinational CHUNK-bit ripple adder. Ports a, b, cin, s, cout, and c_msb (the carry into its top bit).
- Top level holds the FSM, the chunk index counter, the operand registers and the chunk mux/demux.
- Estimated 150–250 lines of RTL.

## Test plan
- **Reset:** hold rst for 2 cycles, then release. Expect busy=0, done=0, sum=0, zero=1.
- **Add, WIDTH=8, CHUNK=1:** a=8'h7F, b=8'h01, sub=0, carry_in=0. Expect done 8 cycles after accept, with sum=8'h80, carry_out=0, overflow=1, zero=0.
- **Subtract to zero, WIDTH=8, CHUNK=4:** a=8'h3C, b=8'h3C, sub=1, carry_in=1. Expect done after 2 cycles, with sum=8'h00, carry_out=1, overflow=0, zero=1.
- **Back-to-back, start held high:**
  - first op a=8'hFF, b=8'h01 gives sum=8'h00, carry_out=1.
  - second op a=8'h10, b=8'h20 gives sum=8'h30.
  - done pulses are NCHUNK+1 cycles apart.
  - start pulses during RUN are ignored.
- **Abort:** assert rst at RUN cycle 3 of an 8-cycle op. Expect no done pulse and outputs at reset values. A new op started immediately afterwards completes normally.
- **Exhaustive sweep, WIDTH=4, CHUNK ∈ {1,2,4}:** all combinations of a, b, sub and carry_in, checked against the reference model {carry_out, sum} = a + (sub ? ~b : b) + carry_in, plus the overflow and zero flags.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and chunk-count helpers for the sequential adder
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// add_slice: combinational CHUNK-bit ripple adder exposing the carry into its top bit
module add_slice #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor, CHUNK bits per clock, with carry/overflow/zero flags
module adder_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW = idx_w(NCHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("adder_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, sum_q, sum_d;
    logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic c_out, c_msb, accept;

    assign a_k = a_q[k_q*CHUNK +: CHUNK];
    assign b_k = b_q[k_q*CHUNK +: CHUNK];

    add_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_k),
        .b    (b_k),
        .cin  (carry_q),
        .s    (s_k),
        .cout (c_out),
        .c_msb(c_msb)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = carry_in;
            k_d     = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            part_d[k_q*CHUNK +: CHUNK] = s_k;
            carry_d = c_out;
            k_d     = k_q + 1'b1;
            // The final chunk's slice supplies both the MSB carry-in and carry-out
            if (k_q == K_LAST) begin
                state_d = DONE;
                sum_d   = part_d;
                cout_d  = c_out;
                ovf_d   = c_msb ^ c_out;
                zero_d  = part_d == '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: scoreboard bench over five adder_seq configurations (8/1, 8/4, 4/1, 4/2, 4/4)
module tb_adder_seq;

    typedef struct packed {
        logic [7:0]  sum;
        logic        co;
        logic        ov;
        logic        z;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sub = 1'b0;
    logic cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [4:0] start_v = '0;
    logic [4:0] busy_v, done_v, co_v, ov_v, z_v;
    logic [7:0] sum_v [5];
    logic [31:0] cyc = '0;
    int n_chk = 0;
    int n_pass = 0;
    exp_t sb [5][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : u
        localparam int W = g < 2 ? 8 : 4;
        localparam int C = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 1 : g == 3 ? 2 : 4;
        logic [W-1:0] s;
        logic bz, dn, co, ov, z;
        adder_seq #(.WIDTH(W), .CHUNK(C)) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .sub      (sub),
            .carry_in (cin),
            .a        (a[W-1:0]),
            .b        (b[W-1:0]),
            .busy     (bz),
            .done     (dn),
            .sum      (s),
            .carry_out(co),
            .overflow (ov),
            .zero     (z)
        );
        assign sum_v[g]  = 8'(s);
        assign busy_v[g] = bz;
        assign done_v[g] = dn;
        assign co_v[g]   = co;
        assign ov_v[g]   = ov;
        assign z_v[g]    = z;
    end

    function automatic int nch(input int g);
        return g == 0 ? 8 : g == 1 ? 2 : g == 2 ? 4 : g == 3 ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 5; g++) begin
            if (done_v[g]) begin
                if (sb[g].size() == 0) begin
                    chk($sformatf("u%0d unexpected done", g), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb[g].pop_front();
                    chk($sformatf("u%0d sum", g), 32'(sum_v[g]), 32'(e.sum));
                    chk($sformatf("u%0d carry_out", g), 32'(co_v[g]), 32'(e.co));
                    chk($sformatf("u%0d overflow", g), 32'(ov_v[g]), 32'(e.ov));
                    chk($sformatf("u%0d zero", g), 32'(z_v[g]), 32'(e.z));
                    chk($sformatf("u%0d done cycle", g), cyc, e.cyc);
                end
            end
        end
    end

    task automatic go(input logic [4:0] m, input logic [7:0] aa, input logic [7:0] bb,
                      input logic s, input logic ci, input exp_t e);
        @(posedge clk); #1;
        a = aa; b = bb; sub = s; cin = ci; start_v = m;
        for (int g = 0; g < 5; g++) begin
            if (m[g]) begin
                e.cyc = cyc + 1 + 32'(nch(g));
                sb[g].push_back(e);
            end
        end
        @(posedge clk); #1;
        start_v = '0;
    endtask

    task automatic drain(input logic [4:0] m);
        int pend;
        for (int t = 0; t < 40; t++) begin
            pend = 0;
            for (int g = 0; g < 5; g++) if (m[g]) pend += sb[g].size();
            if (pend == 0) break;
            @(posedge clk); #1;
        end
        for (int g = 0; g < 5; g++) begin
            if (m[g] && sb[g].size() != 0) begin
                chk($sformatf("u%0d done timeout", g), 32'(sb[g].size()), 32'd0);
                sb[g].delete();
            end
        end
    endtask

    task automatic chk_reset_outs(input int g);
        chk($sformatf("u%0d reset sum", g), 32'(sum_v[g]), 32'd0);
        chk($sformatf("u%0d reset zero", g), 32'(z_v[g]), 32'd1);
        chk($sformatf("u%0d reset carry_out", g), 32'(co_v[g]), 32'd0);
        chk($sformatf("u%0d reset overflow", g), 32'(ov_v[g]), 32'd0);
        chk($sformatf("u%0d reset busy", g), 32'(busy_v[g]), 32'd0);
        chk($sformatf("u%0d reset done", g), 32'(done_v[g]), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [4:0] t;
        logic [3:0] bb4, s4;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int g = 0; g < 5; g++) chk_reset_outs(g);

        e = '{sum: 8'h80, co: 1'b0, ov: 1'b1, z: 1'b0, cyc: 0};
        go(5'b00001, 8'h7F, 8'h01, 1'b0, 1'b0, e);
        drain(5'b00001);

        e = '{sum: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1, cyc: 0};
        go(5'b00010, 8'h3C, 8'h3C, 1'b1, 1'b1, e);
        drain(5'b00010);

        // Back-to-back on CHUNK=4: start stays high through RUN, second op taken in DONE
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h01; sub = 1'b0; cin = 1'b0; start_v = 5'b00010;
        e = '{sum: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1, cyc: cyc + 3};
        sb[1].push_back(e);
        e = '{sum: 8'h30, co: 1'b0, ov: 1'b0, z: 1'b0, cyc: cyc + 6};
        sb[1].push_back(e);
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20;
        repeat (5) @(posedge clk);
        #1 start_v = '0;
        drain(5'b00010);

        @(posedge clk); #1;
        a = 8'h55; b = 8'h22; start_v = 5'b00001;
        @(posedge clk); #1 start_v = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_outs(0);
        repeat (10) @(posedge clk);
        #1 chk("u0 post-abort busy", 32'(busy_v[0]), 32'd0);
        e = '{sum: 8'h03, co: 1'b0, ov: 1'b0, z: 1'b0, cyc: 0};
        go(5'b00001, 8'h01, 8'h02, 1'b0, 1'b0, e);
        drain(5'b00001);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    bb4 = m[1] ? ~4'(bi) : 4'(bi);
                    t = 5'(ai) + 5'(bb4) + 5'(m[0]);
                    s4 = t[3:0];
                    e.sum = 8'(s4);
                    e.co = t[4];
                    e.ov = (ai[3] == bb4[3]) && (s4[3] != ai[3]);
                    e.z = s4 == 4'd0;
                    go(5'b11100, 8'(ai), 8'(bi), m[1], m[0], e);
                    drain(5'b11100);
                end
            end
        end

        repeat (4) @(posedge clk);
        for (int g = 0; g < 5; g++)
            chk($sformatf("u%0d scoreboard empty", g), 32'(sb[g].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
